cvp_mem_responder: RTL and testbench
====================================

# cvp_mem_responder

Synthesizable memory-side responder for the CVP14 memory bus. It is the slave end of the Addr/RD/WR/DataIn/DataOut protocol the CVP14 core drives, and replaces the behavioural DRAM model in synthesized builds. A secondary host port lets the bench or a debug controller preload and dump memory through a valid/ack handshake. CPU accesses always win, and the CPU is never stalled.

## Interface
- ADDR_W, 16, CPU/host address width in words
- DATA_W, 16, word width
- DEPTH, 4096, implemented words; addresses >= DEPTH are out of range
- RD_LAT, 1, cycles from RD sampled to DataOut valid; legal range 1..4

- Clk1  in  1  sole clock; all logic on rising edge
- Reset  in  1  asynchronous, active-high
- Addr  in  ADDR_W  CPU word address
- RD  in  1  CPU read strobe, sampled each cycle
- WR  in  1  CPU write strobe, sampled each cycle
- DataIn  in  DATA_W  CPU write data (the core's DataOut)
- DataOut  out  DATA_W  CPU read data (the core's DataIn)
- HostReq  in  1  host request; held until HostAck
- HostWe  in  1  host request is a write; stable while HostReq is high
- HostAddr  in  ADDR_W  host word address; stable while HostReq is high
- HostWData  in  DATA_W  host write data
- HostAck  out  1  one-cycle completion pulse
- HostRData  out  DATA_W  host read data; valid with HostAck
- Err  out  1  sticky error flag, cleared only by Reset

## Operation
- Storage: DEPTH x DATA_W array with one synchronous access per cycle. Contents are not cleared by Reset.
- CPU write (WR=1, RD=0, in range): the array is written at the edge. The word is readable by a RD in the next cycle.
- CPU read (RD=1, WR=0): the array is read at the edge. The word then passes through a delay line of RD_LAT-1 stages. DataOut updates when the word leaves the delay line and holds that value until the next CPU read completes.
- RD and WR both high: the write is performed and the read returns the pre-write data (read-first). Err is set.
- Out-of-range address: reads return 0 and writes are dropped. Err is set. The same rule applies to host accesses.
- Arbitration: any cycle with RD or WR high belongs to the CPU. The host is granted only in cycles where RD=WR=0. The host can starve indefinitely; this is intentional.
- Host FSM:
  - H_IDLE: on HostReq, go to H_WAIT.
  - H_WAIT: in the first cycle with RD=WR=0, perform the access. A write goes to H_ACK. A read goes to H_RDLAT.
  - H_RDLAT: count RD_LAT-1 cycles, then go to H_ACK. When RD_LAT=1, go directly to H_ACK.
  - H_ACK: drive HostAck=1 with HostRData, then go to H_IDLE.
  - HostReq must drop in the cycle after HostAck. If it is still high, that is a new request.
- CPU and host reads share the delay line. Each entry carries a source tag, so a host result never touches DataOut and a CPU result never touches HostRData.

## Timing
- Reset values: DataOut=0, HostRData=0, HostAck=0, Err=0, FSM=H_IDLE, all delay-line valid bits 0.
- Read latency: RD high at edge N means DataOut is valid after edge N+RD_LAT. Back-to-back reads are fully pipelined at one result per cycle.
- Write-to-read: WR at edge N followed by RD at edge N+1 returns the new data.
- Host write: HostAck is asserted at edge G+1, where G is the grant edge. Host read: HostAck at edge G+RD_LAT.
- Minimum host round trip: 3 cycles (request, grant, ack), when the bus is idle and RD_LAT=1.
- Reset mid-operation: in-flight reads are discarded and a pending host request is dropped without an ack. A host that still holds HostReq after Reset deasserts is treated as issuing a fresh request.

## Structure
- Package cvp_mem_pkg holds:
  - default width constants ADDR_W_DEF and DATA_W_DEF
  - the host FSM enum (H_IDLE, H_WAIT, H_RDLAT, H_ACK)
  - the delay-line entry struct {valid, src_host, data}
- Sub-module cvp_mem_rdpipe: a parameterized RD_LAT-1 stage delay line of tagged entries with asynchronous clear. For RD_LAT=1 it is a pass-through.
- Top level contains the array, arbiter, host FSM, error logic, and output registers.

## Test plan
- Reset, then CPU WR 0x0010=0xBEEF, then RD 0x0010 on the next cycle: DataOut=0xBEEF exactly RD_LAT cycles after the RD edge, for RD_LAT=1 and RD_LAT=3.
- Host writes 0x1234 to 0x0005 while the CPU issues 6 consecutive RDs of other addresses: HostAck only after the RDs stop. A later CPU RD of 0x0005 returns 0x1234.
- Back-to-back CPU RDs of 0..7 with RD_LAT=2: DataOut shows words 0..7 on 8 consecutive cycles. A host read issued in the gap after them returns only on HostRData, and DataOut is unchanged.
- RD=WR=1 at 0x0020, which holds 0x1111, with DataIn=0x2222: DataOut=0x1111 and Err=1. A following RD returns 0x2222.
- Access to address DEPTH (4096): the read returns 0, the write is ignored, and Err stays 1 until Reset.
- Reset asserted during a pending host read: HostAck is never pulsed, all outputs are 0, and array contents are preserved on later reads.

Source files
------------

// File: rtl/cvp_mem_pkg.sv
// Shared types for the CVP14 memory responder: default widths, host FSM states, read-pipe entry.
// Pure declarations; no logic, no latency, no backpressure.
package cvp_mem_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 16;

   typedef enum logic [1:0] {
      H_IDLE,
      H_WAIT,
      H_RDLAT,
      H_ACK
   } host_state_t;

   // src_host routes the word to HostRData instead of DataOut when it leaves the pipe
   typedef struct packed {
      logic                  valid;
      logic                  src_host;
      logic [DATA_W_DEF-1:0] data;
   } rd_entry_t;

endpackage

// File: rtl/cvp_mem_rdpipe.sv
// Tagged read-data delay line of STAGES registers, cleared asynchronously; STAGES=0 is a wire.
// Latency STAGES cycles; no backpressure, one entry accepted every cycle.
module cvp_mem_rdpipe
   import cvp_mem_pkg::*;
#(
   parameter int STAGES = 0
) (
   input  logic      clk,
   input  logic      rst,
   input  rd_entry_t din,
   output rd_entry_t dout
);

   generate
      if (STAGES == 0) begin : g_pass
         logic unused_pass;
         assign unused_pass = clk ^ rst;
         assign dout = din;
      end else begin : g_pipe
         rd_entry_t stage_q [STAGES];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
            end else begin
               stage_q[0] <= din;
               for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
            end
         end

         assign dout = stage_q[STAGES-1];
      end
   endgenerate

endmodule

// File: rtl/cvp_mem_responder.sv
// CVP14 memory-side responder with a host preload/dump port; CPU reads return RD_LAT cycles after RD.
// The CPU is never stalled; the host is granted only bus-idle cycles and may starve.
module cvp_mem_responder
   import cvp_mem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = 4096,
   parameter int RD_LAT = 1
) (
   input  logic              Clk1,
   input  logic              Reset,
   input  logic [ADDR_W-1:0] Addr,
   input  logic              RD,
   input  logic              WR,
   input  logic [DATA_W-1:0] DataIn,
   output logic [DATA_W-1:0] DataOut,
   input  logic              HostReq,
   input  logic              HostWe,
   input  logic [ADDR_W-1:0] HostAddr,
   input  logic [DATA_W-1:0] HostWData,
   output logic              HostAck,
   output logic [DATA_W-1:0] HostRData,
   output logic              Err
);

   localparam int         IDX_W    = $clog2(DEPTH);
   localparam logic [1:0] LAT_LAST = 2'(RD_LAT > 1 ? RD_LAT - 2 : 0);

   logic [DATA_W-1:0] mem [DEPTH];

   host_state_t       hstate_q, hstate_d;
   logic [1:0]        lat_cnt_q;
   logic              cpu_act, cpu_ok, host_ok, grant, acc_ok, mem_we;
   logic [IDX_W-1:0]  acc_idx;
   logic [DATA_W-1:0] wdata, rdata_q;
   logic              rd_zero_q, e0_vld_q, e0_host_q;
   rd_entry_t         pipe_in, pipe_out;
   logic [DATA_W-1:0] dataout_q, hostrdata_q;
   logic              hostack_q, err_q;

   assign cpu_act = RD | WR;
   assign cpu_ok  = {1'b0, Addr} < (ADDR_W+1)'(DEPTH);
   assign host_ok = {1'b0, HostAddr} < (ADDR_W+1)'(DEPTH);
   assign grant   = (hstate_q == H_WAIT) && !cpu_act;
   assign acc_ok  = cpu_act ? cpu_ok : host_ok;
   assign acc_idx = cpu_act ? Addr[IDX_W-1:0] : HostAddr[IDX_W-1:0];
   assign wdata   = cpu_act ? DataIn : HostWData;
   assign mem_we  = acc_ok && (cpu_act ? WR : (grant && HostWe));

   // Single port, read-first: a simultaneous RD+WR returns the old word
   always_ff @(posedge Clk1) begin
      if (mem_we) mem[acc_idx] <= wdata;
      rdata_q   <= mem[acc_idx];
      rd_zero_q <= !acc_ok;
   end

   assign pipe_in = '{valid:    e0_vld_q,
                      src_host: e0_host_q,
                      data:     rd_zero_q ? '0 : DATA_W_DEF'(rdata_q)};

   cvp_mem_rdpipe #(
      .STAGES(RD_LAT - 1)
   ) u_rdpipe (
      .clk (Clk1),
      .rst (Reset),
      .din (pipe_in),
      .dout(pipe_out)
   );

   // The ack cycle itself is ignored so a host still holding HostReq is not re-served
   always_comb begin
      hstate_d = hstate_q;
      case (hstate_q)
         H_IDLE:  if (HostReq && !hostack_q) hstate_d = H_WAIT;
         H_WAIT:  if (grant) hstate_d = (HostWe || RD_LAT == 1) ? H_ACK : H_RDLAT;
         H_RDLAT: if (lat_cnt_q == LAT_LAST) hstate_d = H_ACK;
         H_ACK:   hstate_d = H_IDLE;
         default: hstate_d = H_IDLE;
      endcase
   end

   always_ff @(posedge Clk1 or posedge Reset) begin
      if (Reset) begin
         hstate_q    <= H_IDLE;
         lat_cnt_q   <= '0;
         e0_vld_q    <= 1'b0;
         e0_host_q   <= 1'b0;
         dataout_q   <= '0;
         hostrdata_q <= '0;
         hostack_q   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         hstate_q  <= hstate_d;
         lat_cnt_q <= (hstate_q == H_RDLAT) ? lat_cnt_q + 2'd1 : 2'd0;
         e0_vld_q  <= RD | (grant & ~HostWe);
         e0_host_q <= ~RD;
         hostack_q <= (hstate_q == H_ACK);
         err_q     <= err_q | (RD & WR) | (cpu_act & ~cpu_ok) | (grant & ~host_ok);
         if (pipe_out.valid && !pipe_out.src_host) dataout_q   <= DATA_W'(pipe_out.data);
         if (pipe_out.valid &&  pipe_out.src_host) hostrdata_q <= DATA_W'(pipe_out.data);
      end
   end

   assign DataOut   = dataout_q;
   assign HostRData = hostrdata_q;
   assign HostAck   = hostack_q;
   assign Err       = err_q;

endmodule

// File: tb/tb_cvp_mem_responder.sv
// Bench for cvp_mem_responder: three instances (RD_LAT 1..3) share CPU stimulus, each has its own host requester.
// Stimulus pushes expected read data / host acks into queues; one monitor compares every cycle.
module tb_cvp_mem_responder;

   localparam int NDUT = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] addr = '0, din = '0, haddr = '0, hwd = '0;
   logic        rd = 1'b0, wr = 1'b0, hwe = 1'b0;
   logic        hreq [NDUT];
   logic [15:0] dout [NDUT];
   logic [15:0] hrd  [NDUT];
   logic        hack [NDUT];
   logic        err  [NDUT];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      cvp_mem_responder #(
         .ADDR_W(16), .DATA_W(16), .DEPTH(4096), .RD_LAT(g + 1)
      ) u_dut (
         .Clk1     (clk),
         .Reset    (rst),
         .Addr     (addr),
         .RD       (rd),
         .WR       (wr),
         .DataIn   (din),
         .DataOut  (dout[g]),
         .HostReq  (hreq[g]),
         .HostWe   (hwe),
         .HostAddr (haddr),
         .HostWData(hwd),
         .HostAck  (hack[g]),
         .HostRData(hrd[g]),
         .Err      (err[g])
      );
   end

   typedef struct { int cyc; logic [15:0] d; } rexp_t;
   typedef struct { int g; bit we; logic [15:0] d; } hexp_t;

   rexp_t       rq[$];
   hexp_t       hq[$];
   int          cyc = 0;
   int          err_cyc = 1 << 30;
   int          checks = 0;
   int          errors = 0;
   int          timeouts = 0;
   bit          done = 1'b0;
   int          rp [NDUT] = '{default: 0};
   int          hp [NDUT] = '{default: 0};
   logic [15:0] last_d [NDUT] = '{default: 16'h0};
   logic [15:0] last_h [NDUT] = '{default: 16'h0};

   task automatic chk(input string nm, input int i, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s dut%0d (RD_LAT=%0d) cycle %0d: got %h want %h", nm, i, i + 1, cyc, act, exp);
      end
   endtask

   // Monitor: samples 1 ns after each rising edge
   always @(posedge clk) begin
      cyc++;
      #1;
      if (done) begin
         for (int i = 0; i < NDUT; i++) begin
            chk("reads_completed", i, rp[i], rq.size());
            chk("host_acks_seen", i, hp[i], hq.size());
         end
         chk("host_timeouts", 0, timeouts, 0);
         $display("CHECKS %0d ERRORS %0d", checks, errors);
         $finish;
      end else begin
         for (int i = 0; i < NDUT; i++) begin
            if (rst) begin
               chk("rst_dataout", i, dout[i], 0);
               chk("rst_hostrdata", i, hrd[i], 0);
               chk("rst_hostack", i, hack[i], 0);
               chk("rst_err", i, err[i], 0);
               last_d[i] = '0;
               last_h[i] = '0;
            end else begin
               chk("err", i, err[i], int'(cyc >= err_cyc));
               if (rp[i] < rq.size() && rq[rp[i]].cyc + i + 1 == cyc) begin
                  chk("cpu_rdata", i, dout[i], rq[rp[i]].d);
                  last_d[i] = rq[rp[i]].d;
                  rp[i]++;
               end else begin
                  chk("dataout_hold", i, dout[i], last_d[i]);
               end
               if (hack[i]) begin
                  if (hp[i] >= hq.size()) begin
                     chk("unexpected_hostack", i, hack[i], 0);
                  end else begin
                     chk("hostack_cycle", i, cyc, hq[hp[i]].g + (hq[hp[i]].we ? 1 : i + 1));
                     if (!hq[hp[i]].we) last_h[i] = hq[hp[i]].d;
                     chk("host_rdata", i, hrd[i], last_h[i]);
                     hp[i]++;
                  end
               end else begin
                  chk("hostrdata_hold", i, hrd[i], last_h[i]);
               end
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic cpu_wr(input logic [15:0] a, input logic [15:0] d);
      rd = 1'b0; wr = 1'b1; addr = a; din = d;
      step();
      wr = 1'b0;
   endtask

   task automatic cpu_rd(input logic [15:0] a, input logic [15:0] e);
      rd = 1'b1; wr = 1'b0; addr = a;
      rq.push_back('{cyc + 1, e});
      step();
      rd = 1'b0;
   endtask

   // goff: edges from now until the expected grant edge
   task automatic host_issue(input bit we, input logic [15:0] a, input logic [15:0] wd,
                             input logic [15:0] e, input int goff);
      hwe = we; haddr = a; hwd = wd;
      for (int i = 0; i < NDUT; i++) hreq[i] = 1'b1;
      hq.push_back('{cyc + goff, we, e});
   endtask

   task automatic host_wait();
      int  n = 0;
      bit  busy = 1'b1;
      while (busy && n < 40) begin
         step();
         n++;
         busy = 1'b0;
         for (int i = 0; i < NDUT; i++) begin
            if (hack[i]) hreq[i] = 1'b0;
            if (hreq[i]) busy = 1'b1;
         end
      end
      if (busy) begin
         timeouts++;
         $display("FAIL host_wait: no HostAck within 40 cycles");
         for (int i = 0; i < NDUT; i++) hreq[i] = 1'b0;
      end
      step();
   endtask

   initial begin
      for (int i = 0; i < NDUT; i++) hreq[i] = 1'b0;
      #1 rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      step();

      // Preload, then write followed immediately by a read of the same word
      for (int k = 0; k < 8; k++) cpu_wr(16'(k), 16'hA000 + 16'(k));
      cpu_wr(16'h0010, 16'hBEEF);
      cpu_rd(16'h0010, 16'hBEEF);
      repeat (3) step();

      // Back-to-back reads, then a host read in the gap behind them
      for (int k = 0; k < 8; k++) cpu_rd(16'(k), 16'hA000 + 16'(k));
      host_issue(1'b0, 16'h0010, 16'h0, 16'hBEEF, 2);
      host_wait();

      // Host write starved by six CPU reads
      host_issue(1'b1, 16'h0005, 16'h1234, 16'h0, 7);
      cpu_rd(16'h0000, 16'hA000);
      cpu_rd(16'h0001, 16'hA001);
      cpu_rd(16'h0002, 16'hA002);
      cpu_rd(16'h0003, 16'hA003);
      cpu_rd(16'h0004, 16'hA004);
      cpu_rd(16'h0006, 16'hA006);
      host_wait();
      cpu_rd(16'h0005, 16'h1234);
      repeat (3) step();

      // Simultaneous RD and WR: read-first data, Err raised
      cpu_wr(16'h0020, 16'h1111);
      rd = 1'b1; wr = 1'b1; addr = 16'h0020; din = 16'h2222;
      rq.push_back('{cyc + 1, 16'h1111});
      err_cyc = cyc + 1;
      step();
      rd = 1'b0; wr = 1'b0;
      cpu_rd(16'h0020, 16'h2222);

      // Address DEPTH is out of range for CPU and host alike
      cpu_rd(16'h1000, 16'h0000);
      cpu_wr(16'h1000, 16'h5555);
      cpu_rd(16'h0000, 16'hA000);
      host_issue(1'b0, 16'h1000, 16'h0, 16'h0000, 2);
      host_wait();
      host_issue(1'b1, 16'h1000, 16'h7777, 16'h0, 2);
      host_wait();
      cpu_rd(16'h0000, 16'hA000);
      repeat (5) step();

      // Reset while a host read is pending and a CPU read is in flight
      hwe = 1'b0; haddr = 16'h0010;
      for (int i = 0; i < NDUT; i++) hreq[i] = 1'b1;
      rd = 1'b1; addr = 16'h0010;
      step();
      rd = 1'b0;
      rst = 1'b1;
      err_cyc = 1 << 30;
      for (int i = 0; i < NDUT; i++) hreq[i] = 1'b0;
      repeat (2) step();
      rst = 1'b0;
      repeat (3) step();
      cpu_rd(16'h0010, 16'hBEEF);
      cpu_rd(16'h0005, 16'h1234);
      cpu_rd(16'h0020, 16'h2222);
      repeat (6) step();
      done = 1'b1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
